// File: rtl/cpu_run_controller_pkg.sv
// Shared state encodings and defaults for the CPU run controller.
package cpu_run_controller_pkg;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StBreak = 2'd3
  } run_state_e;

  localparam int unsigned DefaultCntW = 8;

endpackage

// File: rtl/cpu_run_controller.sv
// Turns prescaler ticks into single-clk CPU execute enables under halt/run/step/breakpoint
// control, and counts the instructions executed.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int unsigned PC_W         = 4,
  parameter int unsigned CNT_W        = DefaultCntW,
  parameter bit          RUN_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_adrs,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             at_break,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam run_state_e ResetState = RUN_ON_RESET ? StRun : StHalt;

  run_state_e       state_q, state_d;
  logic             skip_q, skip_d;
  logic             cpu_en_q, at_break_q;
  logic [CNT_W-1:0] cnt_q;
  logic             issue;
  logic             bp_hit;

  // bp_skip lets the instruction we stopped on execute once after resuming.
  assign bp_hit = bp_en && (pc == bp_adrs) && !skip_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    issue   = 1'b0;
    unique case (state_q)
      StHalt: begin
        if (!halt_req) begin
          if (step_req)     state_d = StStep;
          else if (run_req) state_d = StRun;
        end
      end
      StRun: begin
        if (halt_req)      state_d = StHalt;
        else if (step_req) state_d = StStep;
        else if (tick) begin
          if (bp_hit) state_d = StBreak;
          else        issue   = 1'b1;
        end
      end
      StStep: begin
        if (halt_req) state_d = StHalt;
        else if (tick) begin
          issue   = 1'b1;
          state_d = StHalt;
        end
      end
      StBreak: begin
        if (halt_req)      state_d = StHalt;
        else if (step_req) state_d = StStep;
        else if (run_req) begin
          state_d = StRun;
          skip_d  = 1'b1;
        end
      end
    endcase
    if (issue || state_d == StHalt) skip_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ResetState;
      skip_q     <= 1'b0;
      cpu_en_q   <= 1'b0;
      at_break_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      cpu_en_q   <= issue;
      at_break_q <= (state_d == StBreak);
      if (cpu_en_q) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cpu_en   = cpu_en_q;
  assign state    = state_q;
  assign at_break = at_break_q;
  assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench: a request-level model predicts cpu_en timing, state and count.
module tb_cpu_run_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic       bp_en = 1'b0;
  logic [3:0] pc = 4'd0, bp_adrs = 4'd0;
  logic       cpu_en, at_break;
  logic [1:0] state;
  logic [7:0] inst_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // Scoreboard: cycle numbers at which a cpu_en pulse must appear.
  int exp_q[$];

  // Model: mode codes 0=halt 1=run 2=step 3=break.
  int         m_mode = 0;
  bit         m_skip = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  cpu_run_controller #(
    .PC_W(4),
    .CNT_W(8),
    .RUN_ON_RESET(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .run_req(run_req),
    .step_req(step_req),
    .halt_req(halt_req),
    .pc(pc),
    .bp_en(bp_en),
    .bp_adrs(bp_adrs),
    .cpu_en(cpu_en),
    .state(state),
    .at_break(at_break),
    .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares at negedge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("state", int'(state), m_mode);
      check("at_break", int'(at_break), (m_mode == 3) ? 1 : 0);
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("cpu_en_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (cpu_en) begin
        if (exp_q.size() == 0) check("cpu_en_spurious", 1, 0);
        else check("cpu_en_cycle", cyc, exp_q.pop_front());
      end else begin
        check("inst_cnt", int'(inst_cnt), int'(m_cnt));
      end
    end
  end

  // One clk of stimulus; the model applies the request rules to the same inputs.
  task automatic drive(input bit t, input bit r, input bit s, input bit h, input logic [3:0] p);
    int nm;
    bit ns;
    bit iss;
    tick = t; run_req = r; step_req = s; halt_req = h; pc = p;
    nm = m_mode; ns = m_skip; iss = 1'b0;
    if (h) nm = 0;
    else if (m_mode == 0) begin
      if (s) nm = 2;
      else if (r) nm = 1;
    end else if (m_mode == 1) begin
      if (s) nm = 2;
      else if (t) begin
        if (bp_en && p == bp_adrs && !m_skip) nm = 3;
        else iss = 1'b1;
      end
    end else if (m_mode == 2) begin
      if (t) begin
        iss = 1'b1;
        nm = 0;
      end
    end else begin
      if (s) nm = 2;
      else if (r) begin
        nm = 1;
        ns = 1'b1;
      end
    end
    if (iss || nm == 0) ns = 1'b0;
    if (iss) exp_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    m_mode = nm;
    m_skip = ns;
    if (iss) m_cnt++;
    tick = 0; run_req = 0; step_req = 0; halt_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, pc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0;
    m_skip = 1'b0;
    m_cnt = 8'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick = 0; run_req = 0; step_req = 0; halt_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    apply_reset();

    // Halted: ticks do nothing.
    repeat (5) begin
      drive(1, 0, 0, 0, 4'd0);
      idle(1);
    end
    check("halt_no_exec", int'(inst_cnt), 0);

    // Free run, three ticks four clks apart.
    drive(0, 1, 0, 0, 4'd0);
    repeat (3) begin
      drive(1, 0, 0, 0, 4'd1);
      idle(3);
    end
    check("run_cnt", int'(inst_cnt), 3);
    check("run_state", int'(state), 1);

    // Single step from HALT.
    apply_reset();
    drive(0, 0, 1, 0, 4'd0);
    idle(1);
    drive(1, 0, 0, 0, 4'd2);
    idle(2);
    drive(1, 0, 0, 0, 4'd3);
    idle(2);
    check("step_state", int'(state), 0);
    check("step_cnt", int'(inst_cnt), 1);

    // Breakpoint, resume past it, hit again.
    apply_reset();
    bp_en = 1'b1;
    bp_adrs = 4'h5;
    drive(0, 1, 0, 0, 4'd3);
    drive(1, 0, 0, 0, 4'd4);
    idle(1);
    drive(1, 0, 0, 0, 4'd5);
    idle(1);
    check("bp_state", int'(state), 3);
    check("bp_at_break", int'(at_break), 1);
    drive(0, 1, 0, 0, 4'd5);
    drive(1, 0, 0, 0, 4'd5);
    idle(1);
    check("bp_resume_cnt", int'(inst_cnt), 2);
    drive(1, 0, 0, 0, 4'd5);
    idle(1);
    check("bp_rehit", int'(state), 3);

    // All three requests plus a tick in RUN: halt wins, tick dropped.
    drive(0, 1, 0, 0, 4'd5);
    drive(1, 1, 1, 1, 4'd0);
    idle(2);
    check("prio_state", int'(state), 0);
    check("prio_cnt", int'(inst_cnt), 2);

    // 256 instructions wrap the counter.
    apply_reset();
    bp_en = 1'b0;
    drive(0, 1, 0, 0, 4'd0);
    repeat (256) begin
      drive(1, 0, 0, 0, 4'($urandom_range(0, 15)));
      idle(1);
    end
    idle(2);
    check("wrap_cnt", int'(inst_cnt), 0);

    // Reset while a cpu_en is pending.
    drive(1, 0, 0, 0, 4'd0);
    check("pre_reset_cpu_en", int'(cpu_en), 1);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_cpu_en", int'(cpu_en), 0);
    check("reset_state", int'(state), 0);
    check("reset_at_break", int'(at_break), 0);
    check("reset_cnt", int'(inst_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomised mix of requests, ticks and breakpoint changes.
    repeat (3000) begin
      bit t, r, s, h;
      logic [3:0] p;
      if ($urandom_range(0, 63) == 0) bp_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) bp_adrs = 4'($urandom_range(0, 15));
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 11) == 0);
      h = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 1) == 0) ? bp_adrs : 4'($urandom_range(0, 15));
      drive(t, r, s, h, p);
    end
    idle(3);
    check("pending_cpu_en", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
